ctrl_axi_regs: RTL and testbench

AXI4-Lite responder exposing an accelerator's control/status/argument registers on the s_axi_control bus driven by the host-side AXI-Lite initiator. Decodes single-beat reads and writes into a start/done/idle control word, a busy-cycle counter and NUM_ARGS argument registers. Drives a one-cycle launch pulse into the accelerator core and collects its finish pulse.

---
 rtl/ctrl_axi_regs_pkg.sv | 28 ++
 rtl/ctrl_axi_regs.sv | 249 ++++++++++++++++++++++++
 tb/tb_ctrl_axi_regs.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_axi_regs_pkg.sv
// Shared definitions for the accelerator control register block: channel FSM
// states, register map offsets, CTRL bit positions and AXI response codes.
package ctrl_axi_regs_pkg;

   typedef enum logic [1:0] {
      W_IDLE,
      W_ADDR,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   localparam int ADDR_CTRL     = 'h00;
   localparam int ADDR_CYCLES   = 'h08;
   localparam int ADDR_ARG_BASE = 'h10;

   localparam int CTRL_START = 0;
   localparam int CTRL_DONE  = 1;
   localparam int CTRL_IDLE  = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ctrl_axi_regs.sv
// AXI4-Lite responder for the accelerator control/status/argument registers;
// issues a one-cycle launch pulse to the core and tracks its busy time.
//
// state  | meaning
// W_IDLE | waiting for AW and/or W
// W_ADDR | write data held, waiting for address
// W_DATA | write address held, waiting for data
// W_RESP | write committed, BVALID until BREADY
// R_IDLE | waiting for AR
// R_DATA | read data registered, RVALID until RREADY
module ctrl_axi_regs
   import ctrl_axi_regs_pkg::*;
#(
   parameter int AXI_ADDR_BITS = 6,
   parameter int AXI_DATA_BITS = 32,
   parameter int AXI_STRB_BITS = AXI_DATA_BITS / 8,
   parameter int NUM_ARGS      = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       s_axi_control_AWVALID,
   output logic                       s_axi_control_AWREADY,
   input  logic [AXI_ADDR_BITS-1:0]   s_axi_control_AWADDR,
   input  logic                       s_axi_control_WVALID,
   output logic                       s_axi_control_WREADY,
   input  logic [AXI_DATA_BITS-1:0]   s_axi_control_WDATA,
   input  logic [AXI_STRB_BITS-1:0]   s_axi_control_WSTRB,
   output logic                       s_axi_control_BVALID,
   input  logic                       s_axi_control_BREADY,
   output logic [1:0]                 s_axi_control_BRESP,
   input  logic                       s_axi_control_ARVALID,
   output logic                       s_axi_control_ARREADY,
   input  logic [AXI_ADDR_BITS-1:0]   s_axi_control_ARADDR,
   output logic                       s_axi_control_RVALID,
   input  logic                       s_axi_control_RREADY,
   output logic [AXI_DATA_BITS-1:0]   s_axi_control_RDATA,
   output logic [1:0]                 s_axi_control_RRESP,
   output logic                       launch,
   input  logic                       finish,
   output logic [NUM_ARGS*32-1:0]     args
);

   localparam int AW = AXI_ADDR_BITS;

   function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] a);
      return a & ~AW'(3);
   endfunction

   function automatic logic [AW-1:0] arg_addr(input int i);
      return AW'(ADDR_ARG_BASE + 4 * i);
   endfunction

   wr_state_t r_wstate, w_wstate_nxt;
   rd_state_t r_rstate, w_rstate_nxt;

   logic [AW-1:0]                r_awaddr;
   logic [AXI_DATA_BITS-1:0]     r_wdata;
   logic [AXI_STRB_BITS-1:0]     r_wstrb;
   logic [1:0]                   r_bresp;
   logic [AXI_DATA_BITS-1:0]     r_rdata;
   logic [1:0]                   r_rresp;
   logic                         r_start;
   logic                         r_done;
   logic                         r_busy;
   logic                         r_launch;
   logic [31:0]                  r_cycles;
   logic [NUM_ARGS-1:0][31:0]    r_args;

   logic                         w_awready;
   logic                         w_wready;
   logic                         w_commit;
   logic [AW-1:0]                w_c_addr;
   logic [AXI_DATA_BITS-1:0]     w_c_data;
   logic [AXI_STRB_BITS-1:0]     w_c_strb;
   logic                         w_wr_ctrl;
   logic                         w_wr_cyc;
   logic [NUM_ARGS-1:0]          w_wr_arg;
   logic                         w_set_start;
   logic                         w_go;
   logic                         w_ar_hs;
   logic                         w_rd_ctrl;
   logic [AXI_DATA_BITS-1:0]     w_rd_data;
   logic [1:0]                   w_rd_resp;

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_awready    = 1'b0;
      w_wready     = 1'b0;
      w_commit     = 1'b0;
      w_c_addr     = s_axi_control_AWADDR;
      w_c_data     = s_axi_control_WDATA;
      w_c_strb     = s_axi_control_WSTRB;
      case (r_wstate)
         W_IDLE: begin
            w_awready = 1'b1;
            w_wready  = 1'b1;
            if (s_axi_control_AWVALID && s_axi_control_WVALID) begin
               w_commit     = 1'b1;
               w_wstate_nxt = W_RESP;
            end else if (s_axi_control_AWVALID) begin
               w_wstate_nxt = W_DATA;
            end else if (s_axi_control_WVALID) begin
               w_wstate_nxt = W_ADDR;
            end
         end
         W_DATA: begin
            w_wready = 1'b1;
            w_c_addr = r_awaddr;
            if (s_axi_control_WVALID) begin
               w_commit     = 1'b1;
               w_wstate_nxt = W_RESP;
            end
         end
         W_ADDR: begin
            w_awready = 1'b1;
            w_c_data  = r_wdata;
            w_c_strb  = r_wstrb;
            if (s_axi_control_AWVALID) begin
               w_commit     = 1'b1;
               w_wstate_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi_control_BREADY) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_wr_ctrl = (word_addr(w_c_addr) == AW'(ADDR_CTRL));
      w_wr_cyc  = (word_addr(w_c_addr) == AW'(ADDR_CYCLES));
      w_wr_arg  = '0;
      for (int i = 0; i < NUM_ARGS; i++) begin
         w_wr_arg[i] = (word_addr(w_c_addr) == arg_addr(i));
      end
   end

   // A start request is only honoured when the core is fully idle and no launch is pending.
   assign w_set_start = w_commit && w_wr_ctrl && w_c_strb[0] && w_c_data[CTRL_START]
                        && !r_busy && !r_start;
   assign w_go        = r_start && !r_busy;

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (s_axi_control_ARVALID) w_rstate_nxt = R_DATA;
         R_DATA:  if (s_axi_control_RREADY)  w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   assign w_ar_hs   = s_axi_control_ARVALID && (r_rstate == R_IDLE);
   assign w_rd_ctrl = w_ar_hs && (word_addr(s_axi_control_ARADDR) == AW'(ADDR_CTRL));

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_SLVERR;
      if (word_addr(s_axi_control_ARADDR) == AW'(ADDR_CTRL)) begin
         w_rd_data[CTRL_START] = r_start;
         w_rd_data[CTRL_DONE]  = r_done;
         w_rd_data[CTRL_IDLE]  = !r_busy;
         w_rd_resp             = RESP_OKAY;
      end else if (word_addr(s_axi_control_ARADDR) == AW'(ADDR_CYCLES)) begin
         w_rd_data = r_cycles;
         w_rd_resp = RESP_OKAY;
      end else begin
         for (int i = 0; i < NUM_ARGS; i++) begin
            if (word_addr(s_axi_control_ARADDR) == arg_addr(i)) begin
               w_rd_data = r_args[i];
               w_rd_resp = RESP_OKAY;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wstate <= W_IDLE;
         r_rstate <= R_IDLE;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bresp  <= '0;
         r_rdata  <= '0;
         r_rresp  <= '0;
      end else begin
         r_wstate <= w_wstate_nxt;
         r_rstate <= w_rstate_nxt;
         if (s_axi_control_AWVALID && w_awready) r_awaddr <= s_axi_control_AWADDR;
         if (s_axi_control_WVALID && w_wready) begin
            r_wdata <= s_axi_control_WDATA;
            r_wstrb <= s_axi_control_WSTRB;
         end
         if (w_commit) r_bresp <= (w_wr_ctrl || w_wr_cyc || (|w_wr_arg)) ? RESP_OKAY : RESP_SLVERR;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_resp;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_start  <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
         r_launch <= 1'b0;
         r_cycles <= '0;
         r_args   <= '0;
      end else begin
         r_launch <= w_go;
         if (w_go) begin
            r_start  <= 1'b0;
            r_busy   <= 1'b1;
            r_cycles <= '0;
         end else begin
            if (w_set_start) r_start <= 1'b1;
            if (r_busy) begin
               if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
               if (finish) r_busy <= 1'b0;
            end
         end
         // A finish landing on the same edge as a clearing CTRL read keeps done set.
         if (r_busy && finish) r_done <= 1'b1;
         else if (w_rd_ctrl)   r_done <= 1'b0;
         for (int i = 0; i < NUM_ARGS; i++) begin
            if (w_commit && w_wr_arg[i]) begin
               for (int b = 0; b < AXI_STRB_BITS; b++) begin
                  if (w_c_strb[b]) r_args[i][8*b +: 8] <= w_c_data[8*b +: 8];
               end
            end
         end
      end
   end

   // Ready outputs are gated by reset so they read 0 during reset yet assert on the first cycle after release.
   assign s_axi_control_AWREADY = w_awready && reset;
   assign s_axi_control_WREADY  = w_wready && reset;
   assign s_axi_control_ARREADY = (r_rstate == R_IDLE) && reset;
   assign s_axi_control_BVALID  = (r_wstate == W_RESP);
   assign s_axi_control_BRESP   = r_bresp;
   assign s_axi_control_RVALID  = (r_rstate == R_DATA);
   assign s_axi_control_RDATA   = r_rdata;
   assign s_axi_control_RRESP   = r_rresp;
   assign launch                = r_launch;
   assign args                  = r_args;

endmodule

// File: tb/tb_ctrl_axi_regs.sv
// Directed bench for ctrl_axi_regs: table of write/readback vectors plus
// hand-written launch, backpressure and mid-transaction reset sequences.
module tb_ctrl_axi_regs;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          awvalid, awready, wvalid, wready, bvalid, bready;
   logic [5:0]    awaddr;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp;
   logic          arvalid, arready, rvalid, rready;
   logic [5:0]    araddr;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          launch, finish;
   logic [127:0]  args;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   ctrl_axi_regs #(
      .AXI_ADDR_BITS(6),
      .AXI_DATA_BITS(32),
      .AXI_STRB_BITS(4),
      .NUM_ARGS(4)
   ) dut (
      .clock                 (clock),
      .reset                 (reset),
      .s_axi_control_AWVALID (awvalid),
      .s_axi_control_AWREADY (awready),
      .s_axi_control_AWADDR  (awaddr),
      .s_axi_control_WVALID  (wvalid),
      .s_axi_control_WREADY  (wready),
      .s_axi_control_WDATA   (wdata),
      .s_axi_control_WSTRB   (wstrb),
      .s_axi_control_BVALID  (bvalid),
      .s_axi_control_BREADY  (bready),
      .s_axi_control_BRESP   (bresp),
      .s_axi_control_ARVALID (arvalid),
      .s_axi_control_ARREADY (arready),
      .s_axi_control_ARADDR  (araddr),
      .s_axi_control_RVALID  (rvalid),
      .s_axi_control_RREADY  (rready),
      .s_axi_control_RDATA   (rdata),
      .s_axi_control_RRESP   (rresp),
      .launch                (launch),
      .finish                (finish),
      .args                  (args)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          aw_dly;
      int          w_dly;
      logic [1:0]  exp_bresp;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_rresp;
   } vec_t;

   vec_t vecs[9];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for handshake", name);
   endtask

   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int t = 0;
      awaddr = a;
      wdata  = d;
      wstrb  = s;
      bready = 1'b1;
      while (!(aw_done && w_done) && t < 50) begin
         awvalid = !aw_done && (t >= aw_dly);
         wvalid  = !w_done && (t >= w_dly);
         aw_hs   = awvalid && awready;
         w_hs    = wvalid && wready;
         tick();
         t++;
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done  = 1;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (t >= 50) timeout("wr_addr_data");
      lat = 0;
      while (!bvalid && lat < 50) begin
         tick();
         lat++;
      end
      if (lat >= 50) timeout("wr_bvalid");
      resp = bresp;
      tick();
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
      int t = 0;
      araddr  = a;
      arvalid = 1'b1;
      rready  = 1'b1;
      while (!arready && t < 50) begin
         tick();
         t++;
      end
      tick();
      arvalid = 1'b0;
      if (t >= 50) timeout("rd_arready");
      t = 0;
      while (!rvalid && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) timeout("rd_rvalid");
      d = rdata;
      r = rresp;
      tick();
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] d;
      int          lat;
      int          lc;
      bit          ok;

      vecs[0] = '{6'h14, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'hDEADBEEF, 2'b00};
      vecs[1] = '{6'h10, 32'h11223344, 4'hF, 3, 0, 2'b00, 32'h11223344, 2'b00};
      vecs[2] = '{6'h10, 32'h0000AB00, 4'h2, 0, 0, 2'b00, 32'h1122AB44, 2'b00};
      vecs[3] = '{6'h1C, 32'h0A0B0C0D, 4'h9, 0, 2, 2'b00, 32'h0A00000D, 2'b00};
      vecs[4] = '{6'h3C, 32'h12345678, 4'hF, 0, 0, 2'b10, 32'h00000000, 2'b10};
      vecs[5] = '{6'h0C, 32'h87654321, 4'hF, 1, 0, 2'b10, 32'h00000000, 2'b10};
      vecs[6] = '{6'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 32'h00000000, 2'b00};
      vecs[7] = '{6'h17, 32'h55555555, 4'hC, 0, 0, 2'b00, 32'h5555BEEF, 2'b00};
      vecs[8] = '{6'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 32'h00000000, 2'b10};

      awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0; wstrb = '0; bready = 1;
      arvalid = 0; araddr = '0; rready = 1; finish = 0;

      repeat (3) tick();
      check("rst_readies", {awready, wready, arready}, 3'b000);
      check("rst_valids", {bvalid, rvalid, launch}, 3'b000);
      check("rst_resp_data", {bresp, rresp, rdata}, '0);
      check("rst_args", args, '0);
      reset = 1'b1;
      #1;
      check("post_rst_readies", {awready, wready, arready}, 3'b111);
      tick();

      axi_read(6'h00, d, resp);
      check("ctrl_initial", d, 32'h4);

      for (int i = 0; i < 9; i++) begin
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, resp, lat);
         check($sformatf("v%0d_bresp", i), resp, vecs[i].exp_bresp);
         check($sformatf("v%0d_blat", i), lat, 0);
         check($sformatf("v%0d_bsingle", i), bvalid, 1'b0);
         axi_read(vecs[i].addr, d, resp);
         check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
         check($sformatf("v%0d_rresp", i), resp, vecs[i].exp_rresp);
      end
      check("args_after_table", args, {32'h0A00000D, 32'h00000000, 32'h5555BEEF, 32'h1122AB44});

      axi_write(6'h00, 32'h1, 4'hF, 0, 0, resp, lat);
      check("start_bresp", resp, 2'b00);
      check("launch_high", launch, 1'b1);
      lc = cyc;
      tick();
      check("launch_one_cycle", launch, 1'b0);
      axi_read(6'h00, d, resp);
      check("ctrl_busy", d, 32'h0);
      while (cyc < lc + 9) tick();
      finish = 1'b1;
      tick();
      finish = 1'b0;
      axi_read(6'h08, d, resp);
      check("cycles_count", d, 32'd10);
      axi_read(6'h08, d, resp);
      check("cycles_frozen", d, 32'd10);
      axi_read(6'h00, d, resp);
      check("ctrl_done", d, 32'h6);
      axi_read(6'h00, d, resp);
      check("ctrl_done_cleared", d, 32'h4);
      finish = 1'b1;
      tick();
      finish = 1'b0;
      axi_read(6'h00, d, resp);
      check("finish_idle_ignored", d, 32'h4);

      bready = 1'b0;
      awaddr = 6'h18; wdata = 32'hCAFEF00D; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         if (!(bvalid && !awready && !wready && bresp == 2'b00)) ok = 0;
         tick();
      end
      check("bp_bvalid_hold", ok, 1'b1);
      bready = 1'b1;
      tick();
      check("bp_bvalid_release", {bvalid, awready}, 2'b01);

      rready = 1'b0;
      araddr = 6'h18; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      araddr  = 6'h00;
      ok = 1;
      for (int k = 0; k < 5; k++) begin
         if (!(rvalid && !arready && rdata == 32'hCAFEF00D && rresp == 2'b00)) ok = 0;
         tick();
      end
      check("bp_rvalid_hold", ok, 1'b1);
      rready = 1'b1;
      tick();
      check("bp_rvalid_release", {rvalid, arready}, 2'b01);

      axi_write(6'h00, 32'h1, 4'hF, 0, 0, resp, lat);
      check("rst2_launch", launch, 1'b1);
      awaddr = 6'h10; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      check("rst2_in_wdata", {awready, wready}, 2'b01);
      #2;
      reset = 1'b0;
      #1;
      check("rst2_readies", {awready, wready, arready}, 3'b000);
      check("rst2_valids", {bvalid, rvalid, launch}, 3'b000);
      check("rst2_args", args, '0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("rst2_release_readies", {awready, arready}, 2'b11);
      axi_write(6'h10, 32'h00000099, 4'hF, 0, 0, resp, lat);
      check("rst2_wr_bresp", resp, 2'b00);
      axi_read(6'h10, d, resp);
      check("rst2_rd_arg0", d, 32'h99);
      axi_read(6'h00, d, resp);
      check("rst2_ctrl_idle", d, 32'h4);
      axi_read(6'h08, d, resp);
      check("rst2_cycles", d, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
